pts_tx_ctrl: RTL and testbench
==============================

# pts_tx_ctrl

- Transmit sequencer for the flexible parallel-to-serial shift register (MSB-first, ones-fill).
- Accepts words over a valid/ready handshake and stages each one. Drives the register's `load_enable`, `shift_enable` and `parallel_in` so that every bit stays on `serial_out` for exactly `CLKS_PER_BIT` cycles.
- Inserts a configurable idle gap, held at logic 1, between words.
- Sits between the word producer and the serial line driver.

## Interface
- `NUM_BITS`, 16: word width; must match the shift register; ≥2.
- `CLKS_PER_BIT`, 4: clock cycles per serial bit; ≥1.
- `IDLE_GAP`, 1: idle bit periods between words; ≥0.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `tx_data` in NUM_BITS: word to send.
- `tx_valid` in 1: `tx_data` valid.
- `tx_ready` out 1: stage can accept a word.
- `load_enable` out 1: to shift register.
- `shift_enable` out 1: to shift register.
- `parallel_out` out NUM_BITS: staged word, to shift register `parallel_in`.
- `busy` out 1: `state != IDLE` or stage occupied.
- `word_done` out 1: one-cycle pulse in the cycle of a word's last bit-period end.

## Operation
- **Handshake and stage**
  - A transfer occurs in any cycle with `tx_valid && tx_ready`.
  - On a transfer, `tx_data` is written to the `parallel_out` register and `stage_valid` is set.
  - `stage_valid` clears in the cycle that `load_enable` is asserted.
  - `parallel_out` holds its value until the next transfer.
- **FSM states:** IDLE, SHIFT, GAP. Counters are `clk_cnt` (0..CLKS_PER_BIT-1), `bit_cnt` (0..NUM_BITS-1) and `gap_cnt`.
- **IDLE**
  - If `stage_valid`: assert `load_enable`, zero the counters, go to SHIFT.
- **SHIFT**
  - `clk_cnt` increments every cycle.
  - At `clk_cnt == CLKS_PER_BIT-1`: assert `shift_enable`, set `clk_cnt` to 0, increment `bit_cnt`.
  - The shift with `bit_cnt == NUM_BITS-1` is the final shift. In that cycle `word_done` = 1, then:
    - if `IDLE_GAP > 0`: go to GAP with `gap_cnt` = 0;
    - else go to IDLE, or use the chained-load rule below.
- **GAP**
  - Lasts `IDLE_GAP*CLKS_PER_BIT` cycles; the line stays 1.
  - In the final GAP cycle: if `stage_valid`, assert `load_enable` and go to SHIFT with the counters zeroed; else go to IDLE.
- **`tx_ready`**
  - 0 while `rst` is high.
  - Otherwise: `state == IDLE && !stage_valid` (base build); see Configuration for the alternative.
- **Output exclusivity:** `load_enable` and `shift_enable` are never both 1.
- **Reset** (asynchronous, any time, including mid-word):
  - State IDLE, all counters 0, `stage_valid` = 0, `parallel_out` = all ones.
  - `load_enable` = `shift_enable` = `word_done` = `busy` = 0.
  - A word in flight is dropped.
  - The integrator drives the shift register's active-low reset from `~rst`, so the line returns to 1.

## Timing
- **Single word** (transfer in cycle T, base build):
  - `load_enable` in cycle T+1.
  - First bit on the line in cycles T+2..T+1+CLKS_PER_BIT.
  - `shift_enable` in cycles T+1+k·CLKS_PER_BIT for k = 1..NUM_BITS.
  - `word_done` in cycle D = T+1+NUM_BITS·CLKS_PER_BIT.
  - After the final (ones-fill) shift, the line is 1.
- **Gap:** the line idles for exactly `IDLE_GAP·CLKS_PER_BIT` cycles after D.
- **Base build throughput:** no transfer is possible before IDLE. Minimum load-to-load spacing is (NUM_BITS+IDLE_GAP)·CLKS_PER_BIT+2.
- **All outputs** except `tx_ready` are registered-state functions. There is no combinational path from `tx_valid` to `load_enable`.

## Configuration
- **Macro:** `PTS_TX_CTRL_PREFETCH_EN`.
- **Defined:**
  - `tx_ready = !stage_valid` in every state, so the next word is staged during SHIFT or GAP.
  - Chained load with `IDLE_GAP == 0`: in the final-shift cycle, if `stage_valid`, assert `load_enable` instead of `shift_enable` (`shift_enable` = 0). `word_done` is still 1; stay in SHIFT with the counters zeroed.
  - Back-to-back words are seamless; load-to-load spacing is exactly (NUM_BITS+IDLE_GAP)·CLKS_PER_BIT.
- **Undefined:** base build as described in Operation; no chained load.

## Test plan
- **Reset:** hold `rst` = 1 → `tx_ready` = 0, `load_enable` = `shift_enable` = `busy` = 0, `parallel_out` = 16'hFFFF. Release `rst` → `tx_ready` = 1.
- **Single word** (defaults, base build): `tx_data` = 16'hA5C3, transfer in cycle 0 →
  - `load_enable` in cycle 1 with `parallel_out` = A5C3;
  - `shift_enable` in cycles 5, 9, …, 65 (16 pulses);
  - `word_done` in cycle 65; GAP in cycles 66–69; `tx_ready` = 1 in cycle 70.
- **Base build, `tx_valid` held 1 throughout:** second transfer in cycle 70, second `load_enable` in cycle 71. `tx_valid` = 0 → no pulses and `busy` = 0.
- **Prefetch build, `IDLE_GAP` = 0, two words** (transfer in cycle 0, second word staged by cycle 10):
  - cycle 65: `load_enable` = 1, `shift_enable` = 0, `word_done` = 1;
  - next `shift_enable` in cycle 69;
  - second `word_done` in cycle 129.
- **Reset mid-word:** assert `rst` in cycle 30 for 2 cycles → pulses stop immediately and the stage is cleared. After release, no `shift_enable` occurs until a new transfer; a new word sends normally.
- **`CLKS_PER_BIT` = 1, `NUM_BITS` = 4:** transfer in cycle 0 → `load_enable` in cycle 1, `shift_enable` in cycles 2–5, `word_done` in cycle 5.

Source files
------------

// File: rtl/pts_tx_ctrl.sv
// Purpose : transmit sequencer for an MSB-first, ones-fill parallel-to-serial shift register.
// Latency : load_enable one cycle after a transfer; each bit is held for CLKS_PER_BIT cycles.
// Backpres: tx_ready drops while a word is staged (and outside IDLE in the base build).
//
// Ports:
//   clk, rst                    - single clock, asynchronous active-high reset
//   tx_data/tx_valid/tx_ready   - word input handshake
//   load_enable/shift_enable    - controls for the shift register
//   parallel_out                - staged word, wired to the shift register's parallel_in
//   busy                        - FSM active or stage occupied
//   word_done                   - one-cycle pulse at the end of a word's last bit period
//
// Optional feature: define PTS_TX_CTRL_PREFETCH_EN to stage the next word while the
// current one is shifting, giving seamless back-to-back words.
module pts_tx_ctrl #(
    parameter int NUM_BITS     = 16,
    parameter int CLKS_PER_BIT = 4,
    parameter int IDLE_GAP     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BITS-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic                load_enable,
    output logic                shift_enable,
    output logic [NUM_BITS-1:0] parallel_out,
    output logic                busy,
    output logic                word_done
);

    localparam int CW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW         = $clog2(NUM_BITS);
    localparam int GAP_CYCLES = IDLE_GAP * CLKS_PER_BIT;
    localparam int GW         = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NUM_BITS - 1);
    // With no gap the GAP state is unreachable, so the value is irrelevant.
    localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] clk_cnt;
    logic [BW-1:0] bit_cnt;
    logic [GW-1:0] gap_cnt;
    logic          stage_valid;

    logic clk_last;
    logic bit_last;
    logic gap_last;
    logic final_shift;
    logic chain_load;
    logic xfer;

    always_comb begin
        clk_last    = (clk_cnt == CLK_LAST);
        bit_last    = (bit_cnt == BIT_LAST);
        gap_last    = (gap_cnt == GAP_LAST);
        final_shift = (state == S_SHIFT) && clk_last && bit_last;
`ifdef PTS_TX_CTRL_PREFETCH_EN
        // With no gap, the staged word is loaded in place of the final
        // (ones-fill) shift so its first bit follows the previous last bit.
        chain_load  = (IDLE_GAP == 0) && final_shift && stage_valid;
        tx_ready    = !rst && !stage_valid;
`else
        chain_load  = 1'b0;
        tx_ready    = !rst && (state == S_IDLE) && !stage_valid;
`endif
        xfer         = tx_valid && tx_ready;
        load_enable  = ((state == S_IDLE) && stage_valid)
                     || ((state == S_GAP) && gap_last && stage_valid)
                     || chain_load;
        shift_enable = (state == S_SHIFT) && clk_last && !chain_load;
        word_done    = final_shift;
        busy         = (state != S_IDLE) || stage_valid;
    end

    // Stage register: written on a transfer, emptied when handed to the shifter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_valid  <= 1'b0;
            parallel_out <= '1;
        end else if (xfer) begin
            stage_valid  <= 1'b1;
            parallel_out <= tx_data;
        end else if (load_enable) begin
            stage_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_enable) begin
                        state   <= S_SHIFT;
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    if (clk_last) begin
                        clk_cnt <= '0;
                        if (bit_last) begin
                            bit_cnt <= '0;
                            if (chain_load) begin
                                state <= S_SHIFT;
                            end else if (IDLE_GAP > 0) begin
                                state   <= S_GAP;
                                gap_cnt <= '0;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                S_GAP: begin
                    if (gap_last) begin
                        gap_cnt <= '0;
                        if (stage_valid) begin
                            state   <= S_SHIFT;
                            clk_cnt <= '0;
                            bit_cnt <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pts_tx_ctrl.sv
// Purpose : self-checking bench for pts_tx_ctrl using an event scoreboard.
// Latency : n/a (bench).
// Backpres: n/a (bench).
module tb_pts_tx_ctrl;

    typedef struct packed {
        logic [31:0] cyc;
        logic        le;
        logic        se;
        logic        wd;
        logic [15:0] dat;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cyc = 32'd0;
    int          tests = 0;
    int          fails = 0;

    ev_t qa[$];
    ev_t qb[$];
    ev_t qc[$];

    // DUT A: defaults (16 bits, 4 clk/bit, gap 1)
    logic [15:0] tx_data_a, po_a;
    logic        tx_valid_a, tx_ready_a, le_a, se_a, busy_a, wd_a;
    // DUT B: 4 bits, 1 clk/bit, no gap
    logic [3:0]  tx_data_b, po_b;
    logic        tx_valid_b, tx_ready_b, le_b, se_b, busy_b, wd_b;
    // DUT C: 16 bits, 4 clk/bit, no gap
    logic [15:0] tx_data_c, po_c;
    logic        tx_valid_c, tx_ready_c, le_c, se_c, busy_c, wd_c;

    pts_tx_ctrl #(.NUM_BITS(16), .CLKS_PER_BIT(4), .IDLE_GAP(1)) u_a (
        .clk(clk), .rst(rst), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
        .tx_ready(tx_ready_a), .load_enable(le_a), .shift_enable(se_a),
        .parallel_out(po_a), .busy(busy_a), .word_done(wd_a));

    pts_tx_ctrl #(.NUM_BITS(4), .CLKS_PER_BIT(1), .IDLE_GAP(0)) u_b (
        .clk(clk), .rst(rst), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .tx_ready(tx_ready_b), .load_enable(le_b), .shift_enable(se_b),
        .parallel_out(po_b), .busy(busy_b), .word_done(wd_b));

    pts_tx_ctrl #(.NUM_BITS(16), .CLKS_PER_BIT(4), .IDLE_GAP(0)) u_c (
        .clk(clk), .rst(rst), .tx_data(tx_data_c), .tx_valid(tx_valid_c),
        .tx_ready(tx_ready_c), .load_enable(le_c), .shift_enable(se_c),
        .parallel_out(po_c), .busy(busy_c), .word_done(wd_c));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic ev_t mk(input logic [31:0] c, input logic le, input logic se,
                               input logic wd, input logic [15:0] dat);
        ev_t e;
        e.cyc = c; e.le = le; e.se = se; e.wd = wd; e.dat = dat;
        return e;
    endfunction

    task automatic push(input int d, input ev_t e);
        case (d)
            0: qa.push_back(e);
            1: qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int d);
        case (d)
            0: return qa.size();
            1: return qb.size();
            default: return qc.size();
        endcase
    endfunction

    function automatic logic rdy(input int d);
        case (d)
            0: return tx_ready_a;
            1: return tx_ready_b;
            default: return tx_ready_c;
        endcase
    endfunction

    task automatic drive(input int d, input logic v, input logic [15:0] dat);
        case (d)
            0: begin tx_valid_a = v; tx_data_a = dat; end
            1: begin tx_valid_b = v; tx_data_b = dat[3:0]; end
            default: begin tx_valid_c = v; tx_data_c = dat; end
        endcase
    endtask

    // Expected pulses for one word whose load is in cycle l. nsh limits how
    // many shifts are expected; chain replaces the final shift by a load of nxt.
    task automatic push_word(input int d, input logic [31:0] l, input logic [15:0] dat,
                             input int nb, input int cpb, input int nsh,
                             input bit skip_load, input bit chain, input logic [15:0] nxt);
        if (!skip_load) push(d, mk(l, 1'b1, 1'b0, 1'b0, dat));
        for (int k = 1; k <= nsh; k++) begin
            if (k == nb && chain)
                push(d, mk(l + 32'(k * cpb), 1'b1, 1'b0, 1'b1, nxt));
            else
                push(d, mk(l + 32'(k * cpb), 1'b0, 1'b1, (k == nb), 16'h0));
        end
    endtask

    task automatic take(input int d, input ev_t got);
        ev_t e;
        bit  ok;
        ok = 1'b0;
        e  = '0;
        case (d)
            0: if (qa.size() > 0) begin e = qa.pop_front(); ok = 1'b1; end
            1: if (qb.size() > 0) begin e = qb.pop_front(); ok = 1'b1; end
            default: if (qc.size() > 0) begin e = qc.pop_front(); ok = 1'b1; end
        endcase
        chk($sformatf("excl_dut%0d_cyc%0d", d, got.cyc), 64'(got.le && got.se), 64'd0);
        if (ok) begin
            chk($sformatf("ev_dut%0d_cyc%0d", d, e.cyc), 64'(got), 64'(e));
        end else begin
            tests++;
            fails++;
            $display("FAIL unexpected_ev_dut%0d: got %0h expected no pulse", d, got);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (le_a || se_a || wd_a) take(0, mk(cyc, le_a, se_a, wd_a, le_a ? po_a : 16'h0));
            if (le_b || se_b || wd_b) take(1, mk(cyc, le_b, se_b, wd_b, le_b ? {12'h0, po_b} : 16'h0));
            if (le_c || se_c || wd_c) take(2, mk(cyc, le_c, se_c, wd_c, le_c ? po_c : 16'h0));
        end
    endtask

    task automatic wait_rdy(input int d, output logic [31:0] t);
        int n;
        n = 0;
        while (!rdy(d) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!rdy(d)) chk($sformatf("rdy_timeout_dut%0d", d), 64'd0, 64'd1);
        t = cyc;
    endtask

    task automatic wait_until(input logic [31:0] c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_empty(input int d);
        int n;
        n = 0;
        while (qsize(d) != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("drain_dut%0d", d), 64'(qsize(d)), 64'd0);
    endtask

    logic [31:0] t1, t2;

    initial begin
        fork
            monitor();
        join_none
        drive(0, 1'b0, 16'h0);
        drive(1, 1'b0, 16'h0);
        drive(2, 1'b0, 16'h0);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx_ready", 64'(tx_ready_a), 64'd0);
        chk("rst_load",     64'(le_a),       64'd0);
        chk("rst_shift",    64'(se_a),       64'd0);
        chk("rst_busy",     64'(busy_a),     64'd0);
        chk("rst_pout_a",   64'(po_a),       64'hFFFF);
        chk("rst_pout_b",   64'(po_b),       64'hF);
        rst = 1'b0;
        #1;
        chk("rel_tx_ready_a", 64'(tx_ready_a), 64'd1);
        chk("rel_tx_ready_b", 64'(tx_ready_b), 64'd1);

        // Single word A5C3: load T+1, shifts T+5..T+65, done T+65, gap T+66..T+69
        @(negedge clk);
        drive(0, 1'b1, 16'hA5C3);
        wait_rdy(0, t1);
        push_word(0, t1 + 1, 16'hA5C3, 16, 4, 16, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        drive(0, 1'b0, 16'h0);
        wait_until(t1 + 69);
        chk("gap_busy", 64'(busy_a), 64'd1);
`ifdef PTS_TX_CTRL_PREFETCH_EN
        chk("gap_tx_ready", 64'(tx_ready_a), 64'd1);
`else
        chk("gap_tx_ready", 64'(tx_ready_a), 64'd0);
`endif
        @(negedge clk);
        chk("idle_tx_ready", 64'(tx_ready_a), 64'd1);
        chk("idle_busy",     64'(busy_a),     64'd0);
        wait_empty(0);

        // tx_valid held across two words
        drive(0, 1'b1, 16'h1234);
        wait_rdy(0, t1);
        push_word(0, t1 + 1, 16'h1234, 16, 4, 16, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        drive(0, 1'b1, 16'h0FF0);
        wait_rdy(0, t2);
`ifdef PTS_TX_CTRL_PREFETCH_EN
        chk("held_t2", 64'(t2 - t1), 64'd2);
        push_word(0, t1 + 69, 16'h0FF0, 16, 4, 16, 1'b0, 1'b0, 16'h0);
`else
        chk("held_t2", 64'(t2 - t1), 64'd70);
        push_word(0, t2 + 1, 16'h0FF0, 16, 4, 16, 1'b0, 1'b0, 16'h0);
`endif
        @(negedge clk);
        drive(0, 1'b0, 16'h0);
        wait_empty(0);
        repeat (20) @(negedge clk);
        chk("quiet_busy", 64'(busy_a), 64'd0);

        // Reset mid-word: only shifts up to T+29 may appear
        drive(0, 1'b1, 16'hBEEF);
        wait_rdy(0, t1);
        push_word(0, t1 + 1, 16'hBEEF, 16, 4, 7, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        drive(0, 1'b0, 16'h0);
        wait_until(t1 + 30);
        rst = 1'b1;
        #1;
        chk("mid_rst_shift", 64'(se_a),       64'd0);
        chk("mid_rst_busy",  64'(busy_a),     64'd0);
        chk("mid_rst_pout",  64'(po_a),       64'hFFFF);
        chk("mid_rst_rdy",   64'(tx_ready_a), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("mid_rst_pending", 64'(qa.size()), 64'd0);
        chk("mid_rst_idle",    64'(busy_a),    64'd0);
        drive(0, 1'b1, 16'h5A5A);
        wait_rdy(0, t1);
        push_word(0, t1 + 1, 16'h5A5A, 16, 4, 16, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        drive(0, 1'b0, 16'h0);
        wait_empty(0);

        // 4 bits, 1 clk/bit: load T+1, shifts T+2..T+5, done T+5
        drive(1, 1'b1, 16'h0009);
        wait_rdy(1, t1);
        push_word(1, t1 + 1, 16'h0009, 4, 1, 4, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        drive(1, 1'b0, 16'h0);
        wait_empty(1);

        // No gap, two words with tx_valid held
        drive(2, 1'b1, 16'hC001);
        wait_rdy(2, t1);
`ifdef PTS_TX_CTRL_PREFETCH_EN
        push_word(2, t1 + 1, 16'hC001, 16, 4, 16, 1'b0, 1'b1, 16'hD00D);
`else
        push_word(2, t1 + 1, 16'hC001, 16, 4, 16, 1'b0, 1'b0, 16'h0);
`endif
        @(negedge clk);
        drive(2, 1'b1, 16'hD00D);
        wait_rdy(2, t2);
`ifdef PTS_TX_CTRL_PREFETCH_EN
        chk("chain_t2", 64'(t2 - t1), 64'd2);
        push_word(2, t1 + 65, 16'hD00D, 16, 4, 16, 1'b1, 1'b0, 16'h0);
`else
        chk("chain_t2", 64'(t2 - t1), 64'd66);
        push_word(2, t2 + 1, 16'hD00D, 16, 4, 16, 1'b0, 1'b0, 16'h0);
`endif
        @(negedge clk);
        drive(2, 1'b0, 16'h0);
        wait_empty(2);
        repeat (10) @(negedge clk);
        chk("chain_busy", 64'(busy_c), 64'd0);
        chk("end_q_a", 64'(qa.size()), 64'd0);
        chk("end_q_b", 64'(qb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
